prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, field-loadable program memory for the 4-bit CPU, replacing the fixed combinational instruction table. The CPU fetches instructions through a registered read port. A host loader streams a complete program image over a valid/ready port, one word per transfer, starting at address 0. Fetch is marked invalid while a load is in progress, so the core can stall on `fetch_valid`.

## Interface
- `ADDR_W`, default 4: address width. Depth is `DEPTH = 2**ADDR_W`.
- `DATA_W`, default 8: instruction word width.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `fetch_addr`, input, `ADDR_W`: instruction address from the CPU program counter.
- `fetch_data`, output, `DATA_W`: registered instruction word.
- `fetch_valid`, output, 1: `fetch_data` holds valid memory contents.
- `load_start`, input, 1: single-cycle request to begin a full-image load.
- `load_valid`, input, 1: `load_data` is valid.
- `load_data`, input, `DATA_W`: word to be written.
- `load_ready`, output, 1: block can accept a word this cycle.
- `load_busy`, output, 1: load in progress, covering states LOAD and DONE.
- `load_done`, output, 1: one-cycle pulse after the last word is written.
- `load_locked`, output, 1: image is write-locked. See Configuration.

## Operation
- Storage: `DEPTH` x `DATA_W` register array. Contents are not cleared by reset and are undefined until the first load.
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE
  - Each cycle, `fetch_data <= mem[fetch_addr]` and `fetch_valid <= 1`.
  - `load_ready = 0`.
  - `load_start = 1` (and not locked): go to LOAD, set `wr_ptr <= 0`, `fetch_valid <= 0`, `fetch_data <= 0`.
- LOAD
  - `load_ready = 1`.
  - When `load_valid & load_ready`: write `mem[wr_ptr] <= load_data`, then `wr_ptr <= wr_ptr + 1`, wrapping modulo `DEPTH`.
  - When the word accepted has `wr_ptr == DEPTH-1`: go to DONE.
  - `fetch_data` is held at 0 and `fetch_valid` at 0.
  - `load_start` is ignored.
- DONE
  - Lasts one cycle, with `load_done = 1` and `load_ready = 0`.
  - Then go to IDLE.
  - The first valid fetch appears one cycle after returning to IDLE.
- `load_busy = 1` in LOAD and DONE, 0 in IDLE.
- `load_valid` outside LOAD is ignored and never writes.
- `fetch_addr` is unused outside IDLE. Out-of-range is impossible because the address is exactly `ADDR_W` bits.
- Reset mid-load (`n_reset` low at any time):
  - FSM goes to IDLE, `wr_ptr` to 0, and all outputs take their reset values.
  - Words already written keep their values; unwritten words keep their old contents.
  - No `load_done` pulse is produced.

## Timing
- Reset values: `fetch_data = 0`, `fetch_valid = 0`, `load_ready = 0`, `load_busy = 0`, `load_done = 0`, `load_locked = 0`, `wr_ptr = 0`, state IDLE.
- Fetch latency: 1 cycle. An address presented at edge N gives its data after edge N+1.
- After reset release, `fetch_valid` rises after the first rising edge.
- `load_start` at edge N: state is LOAD and `load_ready = 1` from edge N+1 onward.
- Throughput: one word per cycle. A full load with continuous `load_valid` takes `DEPTH` cycles in LOAD, plus 1 cycle in DONE, plus 1 cycle until `fetch_valid`.
- A write takes effect at the accepting edge. A fetch of that address in IDLE afterwards returns the new word.
- `load_start` and `load_valid` asserted together in IDLE: start is honoured; the data is not accepted because `load_ready` was 0.

## Configuration
- Macro: `PROG_MEM_LOCK_EN`.
- Defined:
  - Entering DONE sets a sticky lock flag, driven on `load_locked`.
  - While locked, `load_start` is ignored and the block stays in IDLE.
  - Only `n_reset` clears the lock.
- Undefined:
  - No lock flag; `load_locked` is tied to 0.
  - Any number of reloads is allowed.

## Test plan
- **Reset:** assert `n_reset = 0` mid-activity -> every output is 0 immediately; after release, `fetch_valid = 1` after one edge.
- **Full load and readback:** pulse `load_start`, then stream 16 words `0xB7, 0x01, ... 0xFF` with `load_valid` held high ->
  - `load_done` pulses exactly 17 cycles after start;
  - sweeping `fetch_addr` 0..15 returns each word one cycle later.
- **Backpressure gaps:** drop `load_valid` for 3 cycles after word 5 -> `wr_ptr` holds at 6, no spurious writes, all 16 words correct.
- **Reset mid-load:** reset after 8 words of a second image -> words 0-7 are new, 8-15 are from the previous image, and `load_done` never pulses.
- **Ignored inputs:** `load_valid = 1` with `load_data = 0xAA` in IDLE, and `load_start` pulsed during LOAD -> memory is unchanged and the load continues normally.
- **`PROG_MEM_LOCK_EN` defined:** after one load, pulse `load_start` -> `load_busy` stays 0 and `load_locked = 1`; after a reset, loading is possible again.

Source files
------------

// File: rtl/prog_mem_if.sv
// prog_mem_if: bundles the CPU fetch port and the host loader port of the
// program memory. The master side is the CPU/host and the slave side is prog_mem.
interface prog_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic              load_locked;

    modport master (
        output fetch_addr,
        output load_start,
        output load_valid,
        output load_data,
        input  fetch_data,
        input  fetch_valid,
        input  load_ready,
        input  load_busy,
        input  load_done,
        input  load_locked
    );

    modport slave (
        input  fetch_addr,
        input  load_start,
        input  load_valid,
        input  load_data,
        output fetch_data,
        output fetch_valid,
        output load_ready,
        output load_busy,
        output load_done,
        output load_locked
    );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: field-loadable program memory for the 4-bit CPU.
// The CPU reads through a registered fetch port. A host streams a complete
// image over a valid/ready port starting at address 0. While a load is in
// progress the fetch port reports invalid so the core can stall.
// Optional feature: define PROG_MEM_LOCK_EN to write-lock the image after the
// first completed load; only n_reset clears the lock.
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    prog_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    // Storage has no reset so a reset in the middle of a load keeps old words.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] r_wrPtr;
    logic [DATA_W-1:0] r_fetchData;
    logic              r_fetchValid;

    logic              w_locked;
    logic              w_startLoad;
    logic              w_accept;
    logic              w_lastWord;
    logic              w_loadReady;
    logic              w_loadBusy;
    logic              w_loadDone;

    // A start request is only honoured from IDLE and while the image is unlocked.
    assign w_startLoad = (r_state == IDLE) && bus.load_start && !w_locked;

    // A word is taken only while ready, so load_valid outside LOAD never writes.
    assign w_accept    = w_loadReady && bus.load_valid;

    // The final word of the image is the one accepted at the top address.
    assign w_lastWord  = w_accept && (&r_wrPtr);

`ifdef PROG_MEM_LOCK_EN
    logic r_locked;

    // Sticky lock set when the last word is accepted (entering DONE).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_locked <= 1'b0;
        end else if (w_lastWord) begin
            r_locked <= 1'b1;
        end
    end

    assign w_locked = r_locked;
`else
    assign w_locked = 1'b0;
`endif

    // State register of the load FSM.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> LOAD on start, LOAD -> DONE on last word, DONE lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startLoad) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (w_lastWord) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Loader handshake and status outputs decoded from the current state.
    always_comb begin
        w_loadReady = 1'b0;
        w_loadBusy  = 1'b0;
        w_loadDone  = 1'b0;
        case (r_state)
            LOAD: begin
                w_loadReady = 1'b1;
                w_loadBusy  = 1'b1;
            end
            DONE: begin
                w_loadBusy  = 1'b1;
                w_loadDone  = 1'b1;
            end
            default: begin
                w_loadReady = 1'b0;
            end
        endcase
    end

    // Write pointer restarts at 0 on each load and wraps naturally at DEPTH.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wrPtr <= '0;
        end else if (w_startLoad) begin
            r_wrPtr <= '0;
        end else if (w_accept) begin
            r_wrPtr <= r_wrPtr + 1'b1;
        end
    end

    // Image write port: one word per accepted transfer.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= bus.load_data;
        end
    end

    // Registered fetch: live in IDLE, forced to 0/invalid while a load is pending or running.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_fetchData  <= '0;
            r_fetchValid <= 1'b0;
        end else if ((r_state == IDLE) && !w_startLoad) begin
            r_fetchData  <= r_mem[bus.fetch_addr];
            r_fetchValid <= 1'b1;
        end else begin
            r_fetchData  <= '0;
            r_fetchValid <= 1'b0;
        end
    end

    assign bus.fetch_data  = r_fetchData;
    assign bus.fetch_valid = r_fetchValid;
    assign bus.load_ready  = w_loadReady;
    assign bus.load_busy   = w_loadBusy;
    assign bus.load_done   = w_loadDone;
    assign bus.load_locked = w_locked;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed self-checking bench for prog_mem (ADDR_W=4, DATA_W=8).
// Build with PROG_MEM_LOCK_EN defined to exercise the write-lock behaviour.
module tb_prog_mem;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

`ifdef PROG_MEM_LOCK_EN
    localparam logic LOCK_ON = 1'b1;
`else
    localparam logic LOCK_ON = 1'b0;
`endif

    logic clk     = 1'b0;
    logic n_reset = 1'b1;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0] expMem [DEPTH];

    logic [7:0] img1 [DEPTH] = '{8'hB7, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD,
                                 8'hEF, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hDC, 8'hFF};
    logic [7:0] img2 [DEPTH] = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h69, 8'h96,
                                 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hE1};
    logic [7:0] img3 [DEPTH] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                                 8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
    logic [7:0] img4 [DEPTH] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                 8'h99, 8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h5F, 8'h60};

    prog_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an address and return what the fetch port shows one edge later.
    task automatic readWord(input logic [3:0] a, output logic [7:0] d, output logic v);
        bus.fetch_addr = a;
        tick();
        d = bus.fetch_data;
        v = bus.fetch_valid;
    endtask

    // Offer one word for one cycle.
    task automatic pushWord(input logic [7:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        tick();
        bus.load_valid = 1'b0;
    endtask

    // Pulse load_start for one cycle.
    task automatic doStart();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // In the lock build a completed load locks the image; a reset pulse reopens it.
    task automatic unlockForReload();
`ifdef PROG_MEM_LOCK_EN
        #2;
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        tick();
`endif
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        #1;
        n_reset = 1'b0;
        #2;
        outs = {bus.fetch_data, bus.fetch_valid, bus.load_ready, bus.load_busy,
                bus.load_done, bus.load_locked};
        vecCount++;
        if (outs !== 13'b0) begin
            missCount++;
            $display("[TB] FAIL reset_state: outputs=%b want all zero", outs);
        end
        tick();
        n_reset = 1'b1;
        tick();
        vecCount++;
        if (bus.fetch_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_release_valid: fetch_valid=%b want 1", bus.fetch_valid);
        end
        // Reset in the middle of activity clears every output without a clock edge.
        doStart();
        pushWord(8'h5E);
        pushWord(8'h6F);
        #2;
        n_reset = 1'b0;
        #1;
        outs = {bus.fetch_data, bus.fetch_valid, bus.load_ready, bus.load_busy,
                bus.load_done, bus.load_locked};
        vecCount++;
        if (outs !== 13'b0) begin
            missCount++;
            $display("[TB] FAIL reset_midload_outputs: outputs=%b want all zero", outs);
        end
        #1;
        n_reset = 1'b1;
        tick();
        vecCount++;
        if (bus.fetch_valid !== 1'b1 || bus.load_busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_midload_release: fetch_valid=%b busy=%b want 1/0",
                     bus.fetch_valid, bus.load_busy);
        end
    endtask

    task automatic test_full_load();
        logic [7:0] d;
        logic       v;
        unlockForReload();
        doStart();
        vecCount++;
        if (bus.load_ready !== 1'b1 || bus.load_busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL full_start: ready=%b busy=%b want 1/1", bus.load_ready, bus.load_busy);
        end
        // Start took one cycle; the 16 words make load_done appear 17 cycles after start.
        for (int i = 0; i < DEPTH; i++) begin
            pushWord(img1[i]);
            expMem[i] = img1[i];
            vecCount++;
            if (bus.load_done !== (i == DEPTH - 1)) begin
                missCount++;
                $display("[TB] FAIL full_done_timing cycle %0d: load_done=%b want %b",
                         i + 2, bus.load_done, (i == DEPTH - 1));
            end
        end
        vecCount++;
        if (bus.load_locked !== LOCK_ON || bus.load_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL full_done_state: locked=%b ready=%b want %b/0",
                     bus.load_locked, bus.load_ready, LOCK_ON);
        end
        tick();
        vecCount++;
        if (bus.load_done !== 1'b0 || bus.load_busy !== 1'b0 || bus.fetch_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL full_back_idle: done=%b busy=%b fvalid=%b want 0/0/0",
                     bus.load_done, bus.load_busy, bus.fetch_valid);
        end
        tick();
        vecCount++;
        if (bus.fetch_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL full_first_fetch: fetch_valid=%b want 1", bus.fetch_valid);
        end
        for (int i = 0; i < DEPTH; i++) begin
            readWord(4'(i), d, v);
            vecCount++;
            if (d !== expMem[i] || v !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL full_readback addr %0d: data=%h valid=%b want %h/1", i, d, v, expMem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic       v;
        unlockForReload();
        doStart();
        for (int i = 0; i < 6; i++) begin
            pushWord(img2[i]);
            expMem[i] = img2[i];
        end
        // Gap of three cycles with junk on the data lines: pointer must hold at 6.
        bus.load_data = 8'hEE;
        for (int g = 0; g < 3; g++) begin
            tick();
            vecCount++;
            if (dut.r_wrPtr !== 4'd6 || bus.load_ready !== 1'b1 || bus.load_done !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL gap_hold cycle %0d: wr_ptr=%0d ready=%b done=%b want 6/1/0",
                         g, dut.r_wrPtr, bus.load_ready, bus.load_done);
            end
        end
        for (int i = 6; i < DEPTH; i++) begin
            pushWord(img2[i]);
            expMem[i] = img2[i];
        end
        vecCount++;
        if (bus.load_done !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL gap_done: load_done=%b want 1", bus.load_done);
        end
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            readWord(4'(i), d, v);
            vecCount++;
            if (d !== expMem[i] || v !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL gap_readback addr %0d: data=%h valid=%b want %h/1", i, d, v, expMem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        logic       v;
        logic       sawDone;
        unlockForReload();
        doStart();
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pushWord(img3[i]);
            expMem[i] = img3[i];
            sawDone = sawDone | bus.load_done;
        end
        #2;
        n_reset = 1'b0;
        #1;
        vecCount++;
        if (dut.r_wrPtr !== 4'd0 || bus.load_busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midreset_state: wr_ptr=%0d busy=%b want 0/0", dut.r_wrPtr, bus.load_busy);
        end
        #1;
        n_reset = 1'b1;
        tick();
        sawDone = sawDone | bus.load_done;
        for (int i = 0; i < DEPTH; i++) begin
            readWord(4'(i), d, v);
            sawDone = sawDone | bus.load_done;
            vecCount++;
            if (d !== expMem[i] || v !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL midreset_readback addr %0d: data=%h valid=%b want %h/1", i, d, v, expMem[i]);
            end
        end
        vecCount++;
        if (sawDone !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midreset_no_done: load_done seen=%b want 0", sawDone);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] d;
        logic       v;
        unlockForReload();
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAA;
        for (int g = 0; g < 3; g++) begin
            tick();
            vecCount++;
            if (bus.load_ready !== 1'b0 || bus.load_busy !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL idle_valid_ignored: ready=%b busy=%b want 0/0", bus.load_ready, bus.load_busy);
            end
        end
        bus.load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            readWord(4'(i), d, v);
            vecCount++;
            if (d !== expMem[i]) begin
                missCount++;
                $display("[TB] FAIL idle_valid_nowrite addr %0d: data=%h want %h", i, d, expMem[i]);
            end
        end
        // Start with valid in the same cycle: start honoured, the AA word is not taken.
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAA;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.load_start = (i == 3);
            pushWord(img4[i]);
            bus.load_start = 1'b0;
            expMem[i] = img4[i];
            vecCount++;
            if (bus.load_done !== (i == DEPTH - 1)) begin
                missCount++;
                $display("[TB] FAIL restart_ignored word %0d: load_done=%b want %b",
                         i, bus.load_done, (i == DEPTH - 1));
            end
        end
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            readWord(4'(i), d, v);
            vecCount++;
            if (d !== expMem[i] || v !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL ignored_readback addr %0d: data=%h valid=%b want %h/1", i, d, v, expMem[i]);
            end
        end
    endtask

`ifdef PROG_MEM_LOCK_EN
    task automatic test_lock();
        logic [7:0] d;
        logic       v;
        doStart();
        vecCount++;
        if (bus.load_busy !== 1'b0 || bus.load_locked !== 1'b1 || bus.load_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lock_blocks_start: busy=%b locked=%b ready=%b want 0/1/0",
                     bus.load_busy, bus.load_locked, bus.load_ready);
        end
        readWord(4'd5, d, v);
        vecCount++;
        if (d !== expMem[5] || v !== 1'b1 || bus.load_busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lock_fetch_live: data=%h valid=%b busy=%b want %h/1/0", d, v, bus.load_busy, expMem[5]);
        end
        #2;
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        vecCount++;
        if (bus.load_locked !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL lock_reset_clear: locked=%b want 0", bus.load_locked);
        end
        tick();
        doStart();
        vecCount++;
        if (bus.load_busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL lock_reload_after_reset: busy=%b want 1", bus.load_busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pushWord(img1[i]);
            expMem[i] = img1[i];
        end
        vecCount++;
        if (bus.load_done !== 1'b1 || bus.load_locked !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL lock_relock: done=%b locked=%b want 1/1", bus.load_done, bus.load_locked);
        end
        tick();
        tick();
    endtask
`else
    task automatic test_reload();
        logic [7:0] d;
        logic       v;
        doStart();
        vecCount++;
        if (bus.load_busy !== 1'b1 || bus.load_locked !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reload_allowed: busy=%b locked=%b want 1/0", bus.load_busy, bus.load_locked);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pushWord(img1[i]);
            expMem[i] = img1[i];
        end
        tick();
        tick();
        readWord(4'd15, d, v);
        vecCount++;
        if (d !== 8'hFF || v !== 1'b1 || bus.load_locked !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reload_readback: data=%h valid=%b locked=%b want ff/1/0", d, v, bus.load_locked);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_reset_mid_load();
        test_ignored_inputs();
`ifdef PROG_MEM_LOCK_EN
        test_lock();
`else
        test_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
